// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg: registered 1-to-4 demultiplexer with valid/ready handshakes.
// One producer word is steered by select_i into a one-entry buffer on one of
// four lanes. Each lane's buffer is held until that lane's consumer takes it.
// A lane that pops and is pushed in the same cycle keeps streaming at full rate.
module demux_1to4_reg #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  logic [1:0]      select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic [size-1:0] data1_o,
    output logic [size-1:0] data2_o,
    output logic [size-1:0] data3_o,
    output logic            valid0_o,
    output logic            valid1_o,
    output logic            valid2_o,
    output logic            valid3_o,
    input  logic            ready0_i,
    input  logic            ready1_i,
    input  logic            ready2_i,
    input  logic            ready3_i
);

    logic [3:0]      full_q, full_d;
    logic [size-1:0] buf_q [4];
    logic [size-1:0] buf_d [4];
    logic [3:0]      lane_rdy;
    logic [3:0]      push;
    logic [3:0]      pop;

    assign lane_rdy = {ready3_i, ready2_i, ready1_i, ready0_i};

    // The selected lane can take a word if it is empty or is being drained now.
    assign ready_o = ~full_q[select_i] | lane_rdy[select_i];

    // Per-lane push/pop decode and next-state for the flag and buffer.
    always_comb begin
        push = 4'b0000;
        if (valid_i && ready_o) begin
            push[select_i] = 1'b1;
        end
        pop = full_q & lane_rdy;
        for (int n = 0; n < 4; n++) begin
            full_d[n] = full_q[n];
            buf_d[n]  = buf_q[n];
            if (push[n]) begin
                buf_d[n]  = data_i;
                full_d[n] = 1'b1;
            end else if (pop[n]) begin
                full_d[n] = 1'b0;
            end
        end
    end

    // Lane state registers; reset empties every lane and clears the data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full_q <= 4'b0000;
            for (int n = 0; n < 4; n++) begin
                buf_q[n] <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int n = 0; n < 4; n++) begin
                buf_q[n] <= buf_d[n];
            end
        end
    end

    assign data0_o  = buf_q[0];
    assign data1_o  = buf_q[1];
    assign data2_o  = buf_q[2];
    assign data3_o  = buf_q[3];
    assign valid0_o = full_q[0];
    assign valid1_o = full_q[1];
    assign valid2_o = full_q[2];
    assign valid3_o = full_q[3];

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Testbench for demux_1to4_reg: directed scenarios plus a random soak, all
// compared against per-lane queues of words that have been accepted but not
// yet delivered.
module tb_demux_1to4_reg;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  din;
    logic [1:0]    sel;
    logic          vin;
    logic          rdy_o;
    logic [3:0]    rin;
    logic [W-1:0]  d0, d1, d2, d3;
    logic          v0, v1, v2, v3;
    logic [W-1:0]  dout [4];
    logic [3:0]    vout;

    int n_chk = 0;
    int n_err = 0;

    // Words accepted per lane and not yet consumed, oldest first.
    logic [W-1:0] q [4][$];

    always #5 clk = ~clk;

    always_comb begin
        dout[0] = d0;
        dout[1] = d1;
        dout[2] = d2;
        dout[3] = d3;
        vout    = {v3, v2, v1, v0};
    end

    demux_1to4_reg #(.size(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .data_i   (din),
        .select_i (sel),
        .valid_i  (vin),
        .ready_o  (rdy_o),
        .data0_o  (d0),
        .data1_o  (d1),
        .data2_o  (d2),
        .data3_o  (d3),
        .valid0_o (v0),
        .valid1_o (v1),
        .valid2_o (v2),
        .valid3_o (v3),
        .ready0_i (rin[0]),
        .ready1_i (rin[1]),
        .ready2_i (rin[2]),
        .ready3_i (rin[3])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the inputs currently applied: check outputs against
    // the queues mid-cycle, then apply the handshakes to the queues at the edge.
    task automatic step();
        logic [3:0] pop;
        logic       push;
        logic       exp_rdy;
        @(negedge clk);
        exp_rdy = (q[sel].size() == 0) || rin[sel];
        chk("ready_o", 64'(rdy_o), 64'(exp_rdy));
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("valid%0d", n), 64'(vout[n]), 64'(q[n].size() != 0));
            if (q[n].size() != 0) begin
                chk($sformatf("data%0d", n), 64'(dout[n]), 64'(q[n][0]));
            end
            pop[n] = (q[n].size() != 0) && rin[n];
        end
        push = vin && exp_rdy;
        @(posedge clk);
        for (int n = 0; n < 4; n++) begin
            if (pop[n]) void'(q[n].pop_front());
        end
        if (push) q[sel].push_back(din);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        din   = '0;
        sel   = 2'd0;
        vin   = 1'b0;
        rin   = 4'b0000;
        #12;
        chk("rst_ready", 64'(rdy_o), 64'(1));
        chk("rst_valid", 64'(vout), 64'(0));
        for (int n = 0; n < 4; n++) chk("rst_data", 64'(dout[n]), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic routing to all four lanes, every consumer ready.
        rin = 4'hF;
        for (int i = 0; i < 4; i++) begin
            vin = 1'b1;
            sel = 2'(i);
            din = 32'hA000_0000 + 32'(i);
            step();
        end
        vin = 1'b0;
        step();
        step();

        // Backpressure on lane 1.
        rin = 4'b1101;
        vin = 1'b1;
        sel = 2'd1;
        din = 32'h11;
        step();
        din = 32'h22;
        step();
        chk("bp_hold", 64'(d1), 64'h11);
        chk("bp_refuse", 64'(rdy_o), 64'(0));
        rin = 4'hF;
        step();
        vin = 1'b0;
        chk("bp_new", 64'(d1), 64'h22);
        chk("bp_valid", 64'(v1), 64'(1));
        step();

        // Lane 3 stalled while lane 0 keeps accepting.
        rin = 4'b0111;
        vin = 1'b1;
        sel = 2'd3;
        din = 32'h33;
        step();
        sel = 2'd0;
        din = 32'h55;
        step();
        vin = 1'b0;
        chk("xl_v0", 64'(v0), 64'(1));
        chk("xl_d0", 64'(d0), 64'h55);
        chk("xl_v3", 64'(v3), 64'(1));
        chk("xl_d3", 64'(d3), 64'h33);
        step();
        rin = 4'hF;
        step();
        step();

        // Streaming eight words through lane 2.
        rin = 4'hF;
        sel = 2'd2;
        vin = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            din = 32'(i);
            step();
        end
        vin = 1'b0;
        chk("st_last", 64'(d2), 64'(8));
        step();
        step();

        // Reset while lanes 0 and 2 hold words.
        rin = 4'b0000;
        vin = 1'b1;
        sel = 2'd0;
        din = 32'hDEAD;
        step();
        sel = 2'd2;
        din = 32'hBEEF;
        step();
        vin = 1'b0;
        chk("pre_rst_v", 64'(vout), 64'b0101);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(vout), 64'(0));
        chk("mid_rst_ready", 64'(rdy_o), 64'(1));
        for (int n = 0; n < 4; n++) chk("mid_rst_data", 64'(dout[n]), 64'(0));
        for (int n = 0; n < 4; n++) q[n].delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random soak.
        for (int c = 0; c < 10000; c++) begin
            vin = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            din = $urandom;
            rin = 4'($urandom_range(0, 15));
            step();
        end

        // Drain everything still buffered.
        vin = 1'b0;
        rin = 4'hF;
        for (int c = 0; c < 4; c++) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/demux_1to4_reg.md
# demux_1to4_reg

Registered 1-to-4 demultiplexer with valid/ready handshaking on every port. It steers one input word to one of four output lanes, chosen by a 2-bit select, and holds the word in a one-entry buffer per lane until that lane's consumer accepts it. It is the distribution-side counterpart of the 4-to-1 datapath muxes and sits in the MIPS datapath wherever one producer feeds four independent consumers, for example result routing toward separate write-back or forwarding targets.

## Interface
- size, default 32: width of the data word on the input and on each output lane.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- data_i  input  size  input word.
- select_i  input  2  destination lane for data_i (0..3).
- valid_i  input  1  data_i and select_i are valid this cycle.
- ready_o  output  1  the block accepts the input word this cycle.
- data0_o .. data3_o  output  size each  lane N buffered word.
- valid0_o .. valid3_o  output  1 each  lane N buffer holds a word.
- ready0_i .. ready3_i  input  1 each  lane N consumer accepts the word this cycle.

## Operation
- Per-lane state: full[N] flag (1 bit) and buf[N] register (size bits). dataN_o = buf[N]; validN_o = full[N].
- Input handshake:
  - push = valid_i & ready_o.
  - ready_o = ~full[select_i] | readyN_i[select_i]. This is combinational on select_i, the full flags and the selected lane's ready.
  - ready_o is defined even when valid_i = 0. The producer must not make valid_i depend on ready_o.
- Output handshake: pop[N] = full[N] & readyN_i.
- Lane N next state, evaluated independently for each lane:
  - push to N, no pop: buf[N] <= data_i; full[N] <= 1.
  - pop of N, no push to N: full[N] <= 0; buf[N] holds its value.
  - push and pop of N in the same cycle: buf[N] <= data_i; full[N] stays 1. This gives back-to-back throughput of one word per cycle.
  - neither: no change.
- Only the lane named by select_i can be pushed in a cycle. Any number of lanes can pop in the same cycle.
- Ordering:
  - Words to the same lane leave in arrival order.
  - There is no ordering guarantee across lanes.
- No word is ever dropped or duplicated. A word is accepted once (push) and delivered once (pop).
- While valid_i = 0, data_i and select_i are ignored.
- dataN_o is meaningful only while validN_o = 1. It holds its last value after a pop.

## Timing
- Reset (rst_i = 0, asynchronous, takes effect immediately):
  - all full[N] = 0, all buf[N] = 0.
  - all validN_o = 0, all dataN_o = 0.
  - ready_o = 1.
  - Words held in buffers at reset are discarded.
- Release of reset is sampled synchronously. The first push can occur on the first rising edge with rst_i = 1.
- Latency:
  - A word pushed at edge k appears on dataN_o with validN_o = 1 after edge k.
  - It is consumable in cycle k+1.
  - There is no combinational path from data_i to any dataN_o.
- Throughput: one word per cycle on the input, provided the selected lane is empty or popping in the same cycle.
- Stall:
  - When lane S is full and readyS_i = 0, pushes to S are refused (ready_o = 0 while select_i = S).
  - Pushes to other, non-full lanes are still accepted.
- Stability: while validN_o = 1 and readyN_i = 0, dataN_o and validN_o do not change.

## Test plan
- Reset mid-operation: fill lanes 0 and 2, then assert rst_i = 0 between clock edges. Required: valid0_o..valid3_o = 0 and data0_o..data3_o = 0 immediately, and ready_o = 1.
- Basic routing, all readyN_i = 1: push 0xA0000000..0xA0000003 with select_i = 0,1,2,3 on consecutive cycles. Required:
  - each word appears on its own lane exactly one cycle after its push.
  - each validN_o is a one-cycle pulse.
  - ready_o = 1 throughout.
- Backpressure: ready1_i = 0, push 0x11 to lane 1, then attempt to push 0x22 to lane 1. Required:
  - ready_o = 0 while select_i = 1.
  - data1_o holds 0x11.
  - raising ready1_i pops 0x11 and accepts 0x22 in the same cycle.
  - data1_o = 0x22 on the next cycle.
- Cross-lane independence: lane 3 full and stalled (ready3_i = 0). Push 0x55 to lane 0. Required:
  - the push is accepted and valid0_o = 1 next cycle.
  - lane 3 is unchanged.
- Streaming: select_i = 2 held, ready2_i = 1, 8 words 1..8 pushed on consecutive cycles. Required:
  - data2_o = 1..8 on 8 consecutive cycles with no gap.
  - ready_o = 1 throughout.
- Random soak: random valid_i, select_i and readyN_i over 10k cycles, checked against a per-lane scoreboard. Required:
  - no loss, duplication or reordering within a lane.
  - all handshake stability rules hold.
